mips_phase_sequencer: RTL
=========================

Name: mips_phase_sequencer

Overview:
- Single-clock controller that sequences the uniciclo MIPS datapath.
- Generates the five phase strobes pc_clock, inst_clock, data_clock, muu_clock and reg_clock in order, one group per executed instruction.
- Detects end-of-program: EMPTY_LIMIT consecutive all-zero instructions, or NUM_CYCLES instructions executed.
- On halt, walks the register bank (addresses 0..31) and streams each value out for dump/checking.

Parameters:
- PC_TICKS, 1, clock ticks pc_clock stays high (1..15).
- INST_TICKS, 5, clock ticks inst_clock stays high (1..15).
- DATA_TICKS, 5, clock ticks data_clock and muu_clock stay high (1..15).
- REG_TICKS, 1, clock ticks reg_clock stays high (1..15).
- NUM_CYCLES, 200, maximum instructions executed per run (1..65535).
- EMPTY_LIMIT, 3, consecutive zero instructions that halt the run (1..15).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins a run from IDLE or DONE.
- step_mode  in  1  1 = pause after every instruction until step.
- step  in  1  1-cycle pulse; releases one instruction while paused.
- instruction  in  32  current instruction word from instruction memory.
- pc_clock  out  1  PC update strobe.
- inst_clock  out  1  instruction fetch strobe.
- data_clock  out  1  data memory strobe.
- muu_clock  out  1  mult/div unit strobe (identical to data_clock).
- reg_clock  out  1  register bank write strobe.
- reg_rd_addr  out  5  register bank read address during dump.
- reg_rd_data  in  32  register bank read data (combinational from reg_rd_addr).
- dump_valid  out  1  dump_index/dump_data valid this cycle.
- dump_index  out  5  register number being dumped.
- dump_data  out  32  register value being dumped.
- running  out  1  high from start until halt.
- done  out  1  high after dump completes, until next start.
- halt_cause  out  2  bit0 = empty-instruction limit, bit1 = cycle limit.
- cycle_count  out  16  instructions completed in the current run.

Behaviour:
- Reset (async, reset_n=0): all strobes 0, state IDLE, counters 0, reg_rd_addr 0, dump_valid 0, dump_index 0, dump_data 0, running 0, done 0, halt_cause 0. Reset mid-run aborts immediately; no strobe glitches high.
- States: IDLE, PH_PC, PH_INST, PH_DATA, PH_REG, PAUSE, DUMP, DONE.
- Phase outputs are registered. In each phase state exactly its strobe(s) are 1; in every other state all strobes are 0.
- Each phase holds for its *_TICKS cycles via a 4-bit tick counter, then advances PH_PC -> PH_INST -> PH_DATA -> PH_REG.
- One instruction occupies PC+INST+DATA+REG ticks (12 with defaults).
- Start: IDLE or DONE with start=1 -> PH_PC on the next edge. This clears cycle_count, the empty counter, halt_cause and done, and sets running. start is ignored in all other states.
- Last tick of PH_REG:
  - Sample instruction. If it is 0, the empty counter increments (saturating at 15); otherwise it clears to 0.
  - cycle_count increments (saturating).
  - Halt check uses the post-update values. If empty count == EMPTY_LIMIT, set halt_cause[0]. If cycle_count == NUM_CYCLES, set halt_cause[1]. Both may set together.
  - If either bit is set -> DUMP with running cleared. Otherwise step_mode=1 -> PAUSE, step_mode=0 -> PH_PC.
- PAUSE: all strobes low. step=1 -> PH_PC. Clearing step_mode while in PAUSE also -> PH_PC. step outside PAUSE is ignored.
- DUMP:
  - reg_rd_addr counts 0..31, one per cycle.
  - Each value is registered one cycle later: dump_valid=1, dump_index=previous address, dump_data=reg_rd_data.
  - 32 consecutive valid cycles. After index 31 goes valid -> DONE, done=1, dump_valid=0.
- DONE: outputs hold; halt_cause and cycle_count stay readable until the next start.

Test Plan:
- Reset, start, program of 4 nonzero words then zeros -> strobe pattern pc 1, inst 5, data/muu 5, reg 1 per instruction. Halt after instruction 7 with cycle_count=7 and halt_cause=01.
- All-nonzero program with NUM_CYCLES overridden to 10 -> halt with cycle_count=10, halt_cause=10, running falls exactly after the 10th reg_clock.
- Zeros start at instruction 8 with NUM_CYCLES=10 -> halt_cause=11 (simultaneous limits) at cycle_count=10.
- Pattern 0,0,nonzero,0,0,0 -> the nonzero word resets the counter; halt only after the final three zeros (cycle_count=6).
- Register bank preloaded with reg[i]=0x100+i -> after halt, 32 dump_valid cycles with dump_index 0..31 and dump_data 0x100..0x11F in order, then done=1.
- step_mode=1, with reset_n pulsed low in the middle of PH_DATA of instruction 2:
  - Before reset: the sequencer stops in PAUSE after each reg_clock and resumes only on step.
  - On reset: all outputs return to 0 immediately; a subsequent start reruns with cycle_count restarting from 0.

Source files
------------

// File: rtl/mips_phase_sequencer.sv
// Phase sequencer for the single-cycle MIPS datapath: drives the five phase
// strobes per instruction, detects end-of-program and dumps the register bank.
module mips_phase_sequencer #(
    parameter int unsigned PC_TICKS    = 1,
    parameter int unsigned INST_TICKS  = 5,
    parameter int unsigned DATA_TICKS  = 5,
    parameter int unsigned REG_TICKS   = 1,
    parameter int unsigned NUM_CYCLES  = 200,
    parameter int unsigned EMPTY_LIMIT = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        step_mode,
    input  logic        step,
    input  logic [31:0] instruction,
    output logic        pc_clock,
    output logic        inst_clock,
    output logic        data_clock,
    output logic        muu_clock,
    output logic        reg_clock,
    output logic [4:0]  reg_rd_addr,
    input  logic [31:0] reg_rd_data,
    output logic        dump_valid,
    output logic [4:0]  dump_index,
    output logic [31:0] dump_data,
    output logic        running,
    output logic        done,
    output logic [1:0]  halt_cause,
    output logic [15:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE, PH_PC, PH_INST, PH_DATA, PH_REG, PAUSE, DUMP, DONE
    } state_t;

    localparam logic [3:0]  PC_LAST   = 4'(PC_TICKS - 1);
    localparam logic [3:0]  INST_LAST = 4'(INST_TICKS - 1);
    localparam logic [3:0]  DATA_LAST = 4'(DATA_TICKS - 1);
    localparam logic [3:0]  REG_LAST  = 4'(REG_TICKS - 1);
    localparam logic [15:0] CYC_LIM   = 16'(NUM_CYCLES);
    localparam logic [3:0]  EMPTY_LIM = 4'(EMPTY_LIMIT);

    state_t      state_q, state_d;
    logic [3:0]  tick_q, tick_d;
    logic [3:0]  empty_q, empty_d;
    logic [15:0] cycle_q, cycle_d;
    logic [1:0]  cause_q, cause_d;
    logic [5:0]  dump_cnt_q, dump_cnt_d;
    logic        running_q, running_d;
    logic        done_q, done_d;
    logic        dump_valid_q, dump_valid_d;
    logic [4:0]  dump_index_q, dump_index_d;
    logic [31:0] dump_data_q, dump_data_d;
    logic [3:0]  strobe_q, strobe_d;   // {pc, inst, data, reg}

    logic [3:0]  empty_nxt;
    logic [15:0] cycle_nxt;
    logic [1:0]  cause_nxt;

    // Next-state, counters and registered-output values
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        empty_d      = empty_q;
        cycle_d      = cycle_q;
        cause_d      = cause_q;
        dump_cnt_d   = dump_cnt_q;
        running_d    = running_q;
        done_d       = done_q;
        dump_valid_d = 1'b0;
        dump_index_d = dump_index_q;
        dump_data_d  = dump_data_q;

        empty_nxt = (instruction == '0) ? ((empty_q == 4'hF) ? 4'hF : empty_q + 4'd1) : '0;
        cycle_nxt = (cycle_q == 16'hFFFF) ? 16'hFFFF : cycle_q + 16'd1;
        cause_nxt = {cycle_nxt == CYC_LIM, empty_nxt == EMPTY_LIM};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = PH_PC;
                    tick_d    = '0;
                    cycle_d   = '0;
                    empty_d   = '0;
                    cause_d   = '0;
                    done_d    = 1'b0;
                    running_d = 1'b1;
                end
            end
            PH_PC: begin
                if (tick_q == PC_LAST) begin
                    state_d = PH_INST;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + 4'd1;
                end
            end
            PH_INST: begin
                if (tick_q == INST_LAST) begin
                    state_d = PH_DATA;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + 4'd1;
                end
            end
            PH_DATA: begin
                if (tick_q == DATA_LAST) begin
                    state_d = PH_REG;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + 4'd1;
                end
            end
            PH_REG: begin
                if (tick_q == REG_LAST) begin
                    tick_d  = '0;
                    empty_d = empty_nxt;
                    cycle_d = cycle_nxt;
                    cause_d = cause_nxt;
                    if (|cause_nxt) begin
                        state_d    = DUMP;
                        running_d  = 1'b0;
                        dump_cnt_d = '0;
                    end else if (step_mode) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = PH_PC;
                    end
                end else begin
                    tick_d = tick_q + 4'd1;
                end
            end
            PAUSE: begin
                if (step || !step_mode) begin
                    state_d = PH_PC;
                    tick_d  = '0;
                end
            end
            DUMP: begin
                // Address runs one cycle ahead of the registered dump outputs;
                // count 32 means index 31 is on the outputs this cycle.
                if (dump_cnt_q[5]) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    dump_valid_d = 1'b1;
                    dump_index_d = dump_cnt_q[4:0];
                    dump_data_d  = reg_rd_data;
                    dump_cnt_d   = dump_cnt_q + 6'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes follow the next state so they are high exactly in their phase
        case (state_d)
            PH_PC:   strobe_d = 4'b1000;
            PH_INST: strobe_d = 4'b0100;
            PH_DATA: strobe_d = 4'b0010;
            PH_REG:  strobe_d = 4'b0001;
            default: strobe_d = 4'b0000;
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            empty_q      <= '0;
            cycle_q      <= '0;
            cause_q      <= '0;
            dump_cnt_q   <= '0;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_index_q <= '0;
            dump_data_q  <= '0;
            strobe_q     <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            empty_q      <= empty_d;
            cycle_q      <= cycle_d;
            cause_q      <= cause_d;
            dump_cnt_q   <= dump_cnt_d;
            running_q    <= running_d;
            done_q       <= done_d;
            dump_valid_q <= dump_valid_d;
            dump_index_q <= dump_index_d;
            dump_data_q  <= dump_data_d;
            strobe_q     <= strobe_d;
        end
    end

    assign pc_clock    = strobe_q[3];
    assign inst_clock  = strobe_q[2];
    assign data_clock  = strobe_q[1];
    assign muu_clock   = strobe_q[1];
    assign reg_clock   = strobe_q[0];
    assign reg_rd_addr = dump_cnt_q[4:0];
    assign dump_valid  = dump_valid_q;
    assign dump_index  = dump_index_q;
    assign dump_data   = dump_data_q;
    assign running     = running_q;
    assign done        = done_q;
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_q;

endmodule
